// File: rtl/cardinal_port_arb.sv
// Output-channel arbiter: round-robin fill of the internal-phase VC buffer, drain of the external-phase VC buffer.
// Grant-to-offer latency 1 cycle with toggling polarity; !out_ro holds the offered packet and blocks refill of that VC.
module cardinal_port_arb #(
  parameter int PAC_WIDTH = 64,
  parameter int NUM_REQ   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           polarity,
  input  logic [NUM_REQ-1:0]             req_v,
  input  logic [NUM_REQ*PAC_WIDTH-1:0]   req_d,
  output logic [NUM_REQ-1:0]             req_gnt,
  output logic                           out_so,
  input  logic                           out_ro,
  output logic [PAC_WIDTH-1:0]           out_do,
  output logic [1:0]                     buf_full,
  output logic [15:0]                    pkt_cnt
);

  localparam int PW = $clog2(NUM_REQ);

  logic [1:0]           vld;
  logic [PAC_WIDTH-1:0] data [2];
  logic [PW-1:0]        rr_ptr [2];

  logic                 int_vc;
  logic                 ext_vc;
  logic [PW-1:0]        ptr;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  logic [PW-1:0]        off;
  logic [PW-1:0]        win;
  logic [PW-1:0]        win_nxt;
  logic [PAC_WIDTH-1:0] win_dat;
  int                   sum;
  int                   sum_nxt;

  assign int_vc = polarity;
  assign ext_vc = ~polarity;
  assign ptr    = rr_ptr[int_vc];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_v[i] && (req_d[i*PAC_WIDTH] == int_vc) && !vld[int_vc];
    end
  end

  // Rotate so bit 0 is the pointer position; the first set bit is the offset of the winner.
  always_comb begin
    rot   = NUM_REQ'({elig, elig} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
    end
    sum = int'(ptr) + int'(off);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    win = PW'(sum);
    sum_nxt = sum + 1;
    if (sum_nxt >= NUM_REQ) sum_nxt = 0;
    win_nxt = PW'(sum_nxt);
  end

  always_comb begin
    req_gnt = '0;
    if (found && reset) req_gnt[win] = 1'b1;
  end

  always_comb begin
    win_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) win_dat = req_d[i*PAC_WIDTH +: PAC_WIDTH];
    end
  end

  // Fill and drain always address opposite VCs, so both may update in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld       <= '0;
      data[0]   <= '0;
      data[1]   <= '0;
      rr_ptr[0] <= '0;
      rr_ptr[1] <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (found) begin
        data[int_vc]   <= win_dat;
        vld[int_vc]    <= 1'b1;
        rr_ptr[int_vc] <= win_nxt;
      end
      if (out_so && out_ro) begin
        vld[ext_vc] <= 1'b0;
        pkt_cnt     <= pkt_cnt + 16'd1;
      end
    end
  end

  assign out_so   = vld[ext_vc];
  assign out_do   = out_so ? data[ext_vc] : '0;
  assign buf_full = vld;

endmodule

// File: tb/tb_cardinal_port_arb.sv
// Scoreboard bench for cardinal_port_arb: grants push expected packets per VC, a monitor checks every handshake.
`timescale 1ns/1ps
module tb_cardinal_port_arb;

  logic         clk;
  logic         reset;
  logic         polarity;
  logic [2:0]   req_v;
  logic [191:0] req_d;
  logic [2:0]   req_gnt;
  logic         out_so;
  logic         out_ro;
  logic [63:0]  out_do;
  logic [1:0]   buf_full;
  logic [15:0]  pkt_cnt;

  int total = 0;
  int bad   = 0;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  int   rem  [3];
  int   seq  [3];
  logic vcs  [3];

  localparam logic [2:0] FAIR [12] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                                       3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};

  cardinal_port_arb #(.PAC_WIDTH(64), .NUM_REQ(3)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .req_v(req_v), .req_d(req_d),
    .req_gnt(req_gnt), .out_so(out_so), .out_ro(out_ro), .out_do(out_do),
    .buf_full(buf_full), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pkt(input int r, input int s, input logic v);
    logic [31:0] rr;
    logic [31:0] ss;
    rr = r;
    ss = s;
    return {rr[15:0], ss, 15'h0, v};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < 3; r++) begin
      req_v[r] = (rem[r] != 0);
      req_d[r*64 +: 64] = pkt(r, seq[r], vcs[r]);
    end
  endtask

  task automatic set_reqs(input int r0, input logic v0, input int r1, input logic v1,
                          input int r2, input logic v2);
    rem[0] = r0; vcs[0] = v0; seq[0] = 0;
    rem[1] = r1; vcs[1] = v1; seq[1] = 0;
    rem[2] = r2; vcs[2] = v2; seq[2] = 0;
  endtask

  // One cycle: drive, check grant (and optionally out_do) mid-cycle, book the expected packets.
  task automatic step_x(input logic p, input logic ro, input logic [2:0] eg,
                        input logic co, input logic [63:0] edo);
    polarity = p;
    out_ro   = ro;
    drive_reqs();
    @(negedge clk);
    chk("gnt", 64'(req_gnt), 64'(eg));
    if (co) chk("out_do", out_do, edo);
    for (int r = 0; r < 3; r++) begin
      if (eg[r]) begin
        if (vcs[r]) q1.push_back(pkt(r, seq[r], vcs[r]));
        else        q0.push_back(pkt(r, seq[r], vcs[r]));
      end
    end
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      if (eg[r]) begin
        seq[r]++;
        rem[r]--;
      end
    end
  endtask

  task automatic step(input logic p, input logic ro, input logic [2:0] eg);
    step_x(p, ro, eg, 1'b0, 64'd0);
  endtask

  task automatic do_reset();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    set_reqs(0, 1'b0, 0, 1'b0, 0, 1'b0);
    drive_reqs();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && out_so === 1'b1 && out_ro === 1'b1) begin
      if (out_do[0] == 1'b0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL send_vc0: got %h want no packet", out_do);
        end else chk("send_vc0", out_do, q0.pop_front());
      end else begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL send_vc1: got %h want no packet", out_do);
        end else chk("send_vc1", out_do, q1.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every requester active.
    reset = 1'b0; polarity = 1'b0; out_ro = 1'b1; req_v = 3'b111;
    for (int r = 0; r < 3; r++) req_d[r*64 +: 64] = pkt(r, 0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt", 64'(req_gnt), 64'd0);
      chk("rst_so", 64'(out_so), 64'd0);
      chk("rst_do", out_do, 64'd0);
      chk("rst_cnt", 64'(pkt_cnt), 64'd0);
      chk("rst_full", 64'(buf_full), 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;

    // Single VC0 packet.
    polarity = 1'b0; req_v = 3'b001; req_d[63:0] = 64'h0000_0000_0000_00AA;
    @(negedge clk);
    chk("single_gnt", 64'(req_gnt), 64'd1);
    q0.push_back(64'h0000_0000_0000_00AA);
    @(posedge clk); #1;
    polarity = 1'b1; req_v = 3'b000;
    @(negedge clk);
    chk("single_so", 64'(out_so), 64'd1);
    chk("single_do", out_do, 64'h0000_0000_0000_00AA);
    chk("single_full", 64'(buf_full), 64'd1);
    @(posedge clk); #1;
    polarity = 1'b0;
    @(negedge clk);
    chk("single_cnt", 64'(pkt_cnt), 64'd1);
    chk("single_empty", 64'(buf_full), 64'd0);
    chk("single_idle_do", out_do, 64'd0);
    @(posedge clk); #1;

    // Fairness: three VC0 streams.
    do_reset();
    set_reqs(2, 1'b0, 2, 1'b0, 2, 1'b0);
    for (int c = 0; c < 12; c++) step((c % 2) == 1, 1'b1, FAIR[c]);
    chk("fair_cnt", 64'(pkt_cnt), 64'd6);

    // Backpressure on VC1 only; VC0 keeps flowing.
    do_reset();
    set_reqs(3, 1'b0, 1, 1'b1, 1, 1'b1);
    step_x(1'b1, 1'b1, 3'b010, 1'b1, 64'd0);
    step_x(1'b0, 1'b0, 3'b001, 1'b1, pkt(1, 0, 1'b1));
    step_x(1'b1, 1'b1, 3'b000, 1'b1, pkt(0, 0, 1'b0));
    step_x(1'b0, 1'b0, 3'b001, 1'b1, pkt(1, 0, 1'b1));
    step_x(1'b1, 1'b1, 3'b000, 1'b1, pkt(0, 1, 1'b0));
    chk("bp_cnt_held", 64'(pkt_cnt), 64'd2);
    step_x(1'b0, 1'b1, 3'b001, 1'b1, pkt(1, 0, 1'b1));
    chk("bp_cnt_release", 64'(pkt_cnt), 64'd3);
    step_x(1'b1, 1'b1, 3'b100, 1'b1, pkt(0, 2, 1'b0));
    step_x(1'b0, 1'b1, 3'b000, 1'b1, pkt(2, 0, 1'b1));
    chk("bp_cnt_end", 64'(pkt_cnt), 64'd5);
    chk("bp_full_end", 64'(buf_full), 64'd0);

    // VC mismatch: VC0 request waits for its own phase.
    do_reset();
    set_reqs(1, 1'b0, 1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 3'b010);
    step(1'b0, 1'b1, 3'b001);
    step(1'b1, 1'b1, 3'b000);
    step(1'b0, 1'b1, 3'b000);
    chk("mis_cnt", 64'(pkt_cnt), 64'd2);

    // Counter wrap: one packet per cycle on alternating VCs.
    do_reset();
    set_reqs(32769, 1'b0, 32769, 1'b1, 0, 1'b0);
    for (int k = 0; k <= 65536; k++) begin
      step((k % 2) == 1, 1'b1, ((k % 2) == 1) ? 3'b010 : 3'b001);
      if (k == 65535) chk("wrap_ffff", 64'(pkt_cnt), 64'h0000_0000_0000_FFFF);
    end
    chk("wrap_zero", 64'(pkt_cnt), 64'd0);
    step(1'b1, 1'b0, 3'b010);
    chk("both_full", 64'(buf_full), 64'd3);

    // Reset with both buffers full: contents discarded, nothing sent.
    reset = 1'b0; polarity = 1'b0; out_ro = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 64'(req_gnt), 64'd0);
    @(posedge clk); #1;
    chk("midrst_full", 64'(buf_full), 64'd0);
    chk("midrst_cnt", 64'(pkt_cnt), 64'd0);
    chk("midrst_so", 64'(out_so), 64'd0);
    chk("midrst_q0", 64'(q0.size()), 64'd1);
    chk("midrst_q1", 64'(q1.size()), 64'd1);
    q0.delete();
    q1.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("end_q0", 64'(q0.size()), 64'd0);
    chk("end_q1", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
